// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection phase scheduler: the 3-bit
// red/yellow/green head encoding, the scheduler state set and the
// all-red exit target.
package traffic_pkg;

    // {red, yellow, green}, one-hot
    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    // Scheduler phases
    typedef enum logic [2:0] {
        ALL_RED   = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        WALK      = 3'd5
    } state_t;

    // Where an all-red clearance hands the intersection next
    typedef enum logic [1:0] {
        TGT_NS   = 2'd0,
        TGT_EW   = 2'd1,
        TGT_WALK = 2'd2
    } target_t;

    // Encode one signal head from its green/yellow flags; red otherwise.
    function automatic logic [2:0] head_decode(input logic green, input logic yellow);
        logic [2:0] lights;
        lights = LIGHT_RED;
        if (green) begin
            lights = LIGHT_GREEN;
        end else if (yellow) begin
            lights = LIGHT_YELLOW;
        end
        return lights;
    endfunction

endpackage

// File: rtl/intersection_controller_phase_timer.sv
// Phase dwell timer: a down-counter that is loaded with (duration - 1) on
// phase entry and reports expiry when it reaches zero. It parks at zero
// rather than wrapping, so a phase that is not left stays expired.
module phase_timer #(
    parameter int                 TIMER_W   = 8,
    parameter logic [TIMER_W-1:0] RESET_VAL = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               hold,
    output logic               expired
);

    logic [TIMER_W-1:0] count_reg;

    // Count register: reset value, explicit load, freeze, or decrement to zero
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= RESET_VAL;
        end else if (load) begin
            count_reg <= load_val;
        end else if (!hold && (count_reg != '0)) begin
            count_reg <= count_reg - TIMER_W'(1);
        end
    end

    assign expired = (count_reg == '0);

endmodule

// File: rtl/intersection_controller.sv
// Two-approach intersection phase scheduler. Sequences the north-south and
// east-west heads through green/yellow/all-red, inserts a pedestrian walk
// phase on request and forces all-red while an emergency preemption is
// active. All outputs are a Moore decode of the state register.
module intersection_controller
    import traffic_pkg::*;
#(
    parameter int GREEN_TIME   = 8,
    parameter int YELLOW_TIME  = 3,
    parameter int ALL_RED_TIME = 2,
    parameter int WALK_TIME    = 5,
    parameter int TIMER_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ped_req,
    input  logic       emergency,
    output logic [2:0] ns_lights,
    output logic [2:0] ew_lights,
    output logic       walk,
    output logic       ped_pending
);

    // Timer reload values: each phase dwells exactly its duration because
    // the exit happens on the edge where the count has reached zero.
    localparam logic [TIMER_W-1:0] GREEN_LOAD   = TIMER_W'(GREEN_TIME - 1);
    localparam logic [TIMER_W-1:0] YELLOW_LOAD  = TIMER_W'(YELLOW_TIME - 1);
    localparam logic [TIMER_W-1:0] ALL_RED_LOAD = TIMER_W'(ALL_RED_TIME - 1);
    localparam logic [TIMER_W-1:0] WALK_LOAD    = TIMER_W'(WALK_TIME - 1);

    state_t             state_reg, state_next;
    target_t            target_reg, target_next;
    logic               ped_pending_reg, ped_pending_next;

    logic               timer_expired;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_load_val;
    logic               walk_entry;

    logic [1:0]         head_green;
    logic [1:0]         head_yellow;
    logic [2:0]         head_lights [2];

    // State, all-red target and pedestrian latch registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ALL_RED;
            target_reg      <= TGT_NS;
            ped_pending_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            target_reg      <= target_next;
            ped_pending_reg <= ped_pending_next;
        end
    end

    // Next-state logic: emergency is checked before timer expiry
    always_comb begin
        state_next  = state_reg;
        target_next = target_reg;
        unique case (state_reg)
            ALL_RED: begin
                if (emergency) begin
                    // Park here; once released, north-south gets the road first
                    target_next = TGT_NS;
                end else if (timer_expired) begin
                    unique case (target_reg)
                        TGT_EW:   state_next = EW_GREEN;
                        TGT_WALK: state_next = WALK;
                        default:  state_next = NS_GREEN;
                    endcase
                end
            end
            NS_GREEN: begin
                if (emergency || timer_expired) begin
                    state_next = NS_YELLOW;
                end
            end
            NS_YELLOW: begin
                // Yellow is never cut short, even under preemption
                if (timer_expired) begin
                    state_next  = ALL_RED;
                    target_next = emergency ? TGT_NS : TGT_EW;
                end
            end
            EW_GREEN: begin
                if (emergency || timer_expired) begin
                    state_next = EW_YELLOW;
                end
            end
            EW_YELLOW: begin
                if (timer_expired) begin
                    state_next = ALL_RED;
                    if (!emergency && ped_pending_reg) begin
                        target_next = TGT_WALK;
                    end else begin
                        target_next = TGT_NS;
                    end
                end
            end
            WALK: begin
                // An emergency abandons the walk outright; the request is not restored
                if (emergency || timer_expired) begin
                    state_next  = ALL_RED;
                    target_next = TGT_NS;
                end
            end
            default: begin
                state_next  = ALL_RED;
                target_next = TGT_NS;
            end
        endcase
    end

    // Timer control: reload on every phase change, and keep re-arming the
    // clearance while an emergency pins the intersection in all-red so that
    // a full clearance always follows the release.
    always_comb begin
        timer_load = (state_next != state_reg) ||
                     ((state_reg == ALL_RED) && emergency);
        unique case (state_next)
            NS_GREEN, EW_GREEN:   timer_load_val = GREEN_LOAD;
            NS_YELLOW, EW_YELLOW: timer_load_val = YELLOW_LOAD;
            WALK:                 timer_load_val = WALK_LOAD;
            default:              timer_load_val = ALL_RED_LOAD;
        endcase
    end

    // Pedestrian latch: a new request beats the clear on walk entry
    always_comb begin
        walk_entry       = (state_next == WALK) && (state_reg != WALK);
        ped_pending_next = ped_req || (ped_pending_reg && !walk_entry);
    end

    // Re-arming (not freezing) is how the clearance is held, so hold stays low
    phase_timer #(
        .TIMER_W   (TIMER_W),
        .RESET_VAL (ALL_RED_LOAD)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_load_val),
        .hold     (1'b0),
        .expired  (timer_expired)
    );

    // Per-head green/yellow flags from the state register (index 0 = NS, 1 = EW)
    always_comb begin
        head_green  = {state_reg == EW_GREEN,  state_reg == NS_GREEN};
        head_yellow = {state_reg == EW_YELLOW, state_reg == NS_YELLOW};
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_head
            assign head_lights[gi] = head_decode(head_green[gi], head_yellow[gi]);
        end
    endgenerate

    assign ns_lights   = head_lights[0];
    assign ew_lights   = head_lights[1];
    assign walk        = (state_reg == WALK);
    assign ped_pending = ped_pending_reg;

endmodule

// File: tb/tb_intersection_controller.sv
// Self-checking bench for intersection_controller: a reset-to-period vector
// table, hand-written corner sequences and randomized traffic compared
// against a dwell-count reference model.
module tb_intersection_controller;

    localparam int GT  = 8;
    localparam int YT  = 3;
    localparam int ART = 2;
    localparam int WT  = 5;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    // Reference model phase names
    localparam int P_AR  = 0;
    localparam int P_NSG = 1;
    localparam int P_NSY = 2;
    localparam int P_EWG = 3;
    localparam int P_EWY = 4;
    localparam int P_WK  = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ped_req = 1'b0;
    logic       emergency = 1'b0;
    logic [2:0] ns_lights;
    logic [2:0] ew_lights;
    logic       walk;
    logic       ped_pending;

    int checks = 0;
    int errors = 0;
    int cycle_no = 0;

    always #5 clk = ~clk;

    intersection_controller #(
        .GREEN_TIME   (GT),
        .YELLOW_TIME  (YT),
        .ALL_RED_TIME (ART),
        .WALK_TIME    (WT),
        .TIMER_W      (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ped_req     (ped_req),
        .emergency   (emergency),
        .ns_lights   (ns_lights),
        .ew_lights   (ew_lights),
        .walk        (walk),
        .ped_pending (ped_pending)
    );

    // Reference model: current phase, cycles left in it (including the
    // current one), the phase the next all-red hands over to, and the
    // outstanding pedestrian request.
    int m_ph;
    int m_left;
    int m_tgt;
    bit m_pend;

    function automatic int dur(input int p);
        case (p)
            P_NSG, P_EWG: return GT;
            P_NSY, P_EWY: return YT;
            P_WK:         return WT;
            default:      return ART;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit p, input bit e);
        int nph;
        int nleft;
        int ntgt;
        if (r) begin
            m_ph = P_AR; m_left = ART; m_tgt = P_NSG; m_pend = 1'b0;
            return;
        end
        nph = m_ph;
        nleft = m_left - 1;
        ntgt = m_tgt;
        case (m_ph)
            P_AR: begin
                if (e) begin
                    ntgt = P_NSG; nleft = ART;
                end else if (m_left == 1) begin
                    nph = m_tgt;
                end
            end
            P_NSG: if (e || m_left == 1) nph = P_NSY;
            P_NSY: if (m_left == 1) begin nph = P_AR; ntgt = e ? P_NSG : P_EWG; end
            P_EWG: if (e || m_left == 1) nph = P_EWY;
            P_EWY: if (m_left == 1) begin nph = P_AR; ntgt = (!e && m_pend) ? P_WK : P_NSG; end
            default: if (e || m_left == 1) begin nph = P_AR; ntgt = P_NSG; end
        endcase
        if (nph != m_ph) nleft = dur(nph);
        m_pend = p || (m_pend && !(nph == P_WK && m_ph != P_WK));
        m_ph = nph;
        m_left = nleft;
        m_tgt = ntgt;
    endtask

    function automatic logic [2:0] exp_ns(input int p);
        return (p == P_NSG) ? G : (p == P_NSY) ? Y : R;
    endfunction

    function automatic logic [2:0] exp_ew(input int p);
        return (p == P_EWG) ? G : (p == P_EWY) ? Y : R;
    endfunction

    // Drive inputs away from the edge, clock once, advance the model, settle
    task automatic drive_tick(input bit r, input bit p, input bit e);
        @(negedge clk);
        reset = r; ped_req = p; emergency = e;
        @(posedge clk);
        model_step(r, p, e);
        #1;
        cycle_no++;
    endtask

    // One transaction checked against the reference model
    task automatic cyc(input bit r, input bit p, input bit e);
        logic [7:0] got;
        logic [7:0] want;
        drive_tick(r, p, e);
        got  = {ns_lights, ew_lights, walk, ped_pending};
        want = {exp_ns(m_ph), exp_ew(m_ph), (m_ph == P_WK), m_pend};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL model cyc %0d r=%0b p=%0b e=%0b: got ns=%b ew=%b walk=%b pend=%b, want ns=%b ew=%b walk=%b pend=%b",
                     cycle_no, r, p, e, got[7:5], got[4:2], got[1], got[0],
                     want[7:5], want[4:2], want[1], want[0]);
        end else begin
            $display("cyc %0d r=%0b p=%0b e=%0b ns=%b ew=%b walk=%b pend=%b",
                     cycle_no, r, p, e, ns_lights, ew_lights, walk, ped_pending);
        end
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Run idle cycles until the model reaches phase p (bounded)
    task automatic wait_phase(input int p, input string nm);
        int n;
        n = 0;
        while (m_ph != p && n < 200) begin
            cyc(1'b0, 1'b0, 1'b0);
            n++;
        end
        chk({nm, "_reached"}, 8'(m_ph == p), 8'd1);
    endtask

    typedef struct {
        bit         r;
        bit         p;
        bit         e;
        logic [2:0] ns;
        logic [2:0] ew;
        bit         wk;
        bit         pd;
    } vec_t;

    vec_t tab[$];

    task automatic add(input int n, input bit r, input logic [2:0] ns, input logic [2:0] ew);
        vec_t v;
        v.r = r; v.p = 1'b0; v.e = 1'b0; v.ns = ns; v.ew = ew; v.wk = 1'b0; v.pd = 1'b0;
        repeat (n) tab.push_back(v);
    endtask

    initial begin
        int n;
        int walks;
        bit prev_walk;
        int em_cnt;
        bit rr, pp, ee;

        // Reset and one full period with no requests
        add(2, 1'b1, R, R);
        add(1, 1'b0, R, R);
        add(GT, 1'b0, G, R);
        add(YT, 1'b0, Y, R);
        add(ART, 1'b0, R, R);
        add(GT, 1'b0, R, G);
        add(YT, 1'b0, R, Y);
        add(ART, 1'b0, R, R);
        add(GT, 1'b0, G, R);
        foreach (tab[i]) begin
            drive_tick(tab[i].r, tab[i].p, tab[i].e);
            checks++;
            if ({ns_lights, ew_lights, walk, ped_pending} !==
                {tab[i].ns, tab[i].ew, tab[i].wk, tab[i].pd}) begin
                errors++;
                $display("FAIL vec[%0d]: got ns=%b ew=%b walk=%b pend=%b, want ns=%b ew=%b walk=%b pend=%b",
                         i, ns_lights, ew_lights, walk, ped_pending,
                         tab[i].ns, tab[i].ew, tab[i].wk, tab[i].pd);
            end else begin
                $display("vec[%0d] r=%0b ns=%b ew=%b walk=%b pend=%b",
                         i, tab[i].r, ns_lights, ew_lights, walk, ped_pending);
            end
        end

        // Pedestrian request during NS green gives one walk phase
        cyc(1'b1, 1'b0, 1'b0);
        wait_phase(P_NSG, "ped_nsg");
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("ped_latch_next_cycle", 8'(ped_pending), 8'd1);
        n = 0;
        while (!walk && n < 200) begin
            cyc(1'b0, 1'b0, 1'b0);
            n++;
        end
        chk("walk_reached", 8'(walk), 8'd1);
        chk("walk_clears_pending", 8'(ped_pending), 8'd0);
        chk("walk_heads_red", {2'b00, ns_lights, ew_lights}, {2'b00, R, R});
        n = 1;
        while (walk && n < 50) begin
            cyc(1'b0, 1'b0, 1'b0);
            if (walk) n++;
        end
        chk("walk_length", 8'(n), 8'(WT));
        chk("after_walk_red1", 8'(ns_lights), 8'(R));
        cyc(1'b0, 1'b0, 1'b0);
        chk("after_walk_red2", 8'(ns_lights), 8'(R));
        cyc(1'b0, 1'b0, 1'b0);
        chk("after_walk_ns_green", 8'(ns_lights), 8'(G));

        // Emergency on cycle 3 of EW green, held 10 cycles
        cyc(1'b1, 1'b0, 1'b0);
        wait_phase(P_EWG, "em_ewg");
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("em_ew_yellow_next", 8'(ew_lights), 8'(Y));
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("em_yellow_full_time", 8'(ew_lights), 8'(Y));
        cyc(1'b0, 1'b0, 1'b1);
        chk("em_all_red", {2'b00, ns_lights, ew_lights}, {2'b00, R, R});
        repeat (6) cyc(1'b0, 1'b0, 1'b1);
        chk("em_all_red_held", {2'b00, ns_lights, ew_lights}, {2'b00, R, R});
        cyc(1'b0, 1'b0, 1'b0);
        chk("em_release_clear", 8'(ns_lights), 8'(R));
        cyc(1'b0, 1'b0, 1'b0);
        chk("em_release_ns_green", 8'(ns_lights), 8'(G));

        // Emergency on cycle 2 of WALK
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        wait_phase(P_WK, "em_walk");
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("em_walk_abort", {1'b0, walk, ns_lights, ew_lights}, {2'b00, R, R});
        repeat (3) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("em_walk_release_clear", 8'(ns_lights), 8'(R));
        cyc(1'b0, 1'b0, 1'b0);
        chk("em_walk_ns_green", 8'(ns_lights), 8'(G));
        chk("em_walk_not_repended", 8'(ped_pending), 8'd0);

        // Three requests in one period give exactly one walk
        cyc(1'b1, 1'b0, 1'b0);
        walks = 0;
        prev_walk = 1'b0;
        for (int i = 0; i < 75; i++) begin
            cyc(1'b0, (i == 3 || i == 10 || i == 17), 1'b0);
            if (walk && !prev_walk) walks++;
            prev_walk = walk;
        end
        chk("multi_req_one_walk", 8'(walks), 8'd1);

        // Request coincident with walk entry survives and yields a second walk
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        n = 0;
        while (!(m_ph == P_AR && m_tgt == P_WK && m_left == 1) && n < 200) begin
            cyc(1'b0, 1'b0, 1'b0);
            n++;
        end
        cyc(1'b0, 1'b1, 1'b0);
        chk("coincident_walk", 8'(walk), 8'd1);
        chk("coincident_pending_kept", 8'(ped_pending), 8'd1);
        walks = 0;
        prev_walk = 1'b1;
        for (int i = 0; i < 45; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            if (walk && !prev_walk) walks++;
            prev_walk = walk;
        end
        chk("coincident_second_walk", 8'(walks), 8'd1);

        // Reset on cycle 2 of NS yellow
        cyc(1'b1, 1'b0, 1'b0);
        wait_phase(P_NSG, "rst_nsg");
        cyc(1'b0, 1'b1, 1'b0);
        wait_phase(P_NSY, "rst_nsy");
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("rst_mid_all_red", {2'b00, ns_lights, ew_lights}, {2'b00, R, R});
        chk("rst_mid_pending", 8'(ped_pending), 8'd0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("rst_mid_clear", 8'(ns_lights), 8'(R));
        cyc(1'b0, 1'b0, 1'b0);
        chk("rst_mid_ns_green", 8'(ns_lights), 8'(G));

        // Randomized traffic against the model
        em_cnt = 0;
        for (int i = 0; i < 1500; i++) begin
            rr = ($urandom_range(0, 299) == 0);
            pp = ($urandom_range(0, 19) == 0);
            if (em_cnt > 0) begin
                em_cnt--;
                ee = 1'b1;
            end else begin
                ee = 1'b0;
                if ($urandom_range(0, 79) == 0) em_cnt = $urandom_range(1, 15);
            end
            cyc(rr, pp, ee);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/intersection_controller.md
# intersection_controller

Phase scheduler for a two-approach intersection. It sequences the north-south and east-west signal heads, which use the team's standard 3-bit red/yellow/green light encoding. It also inserts a pedestrian walk phase on request and forces all-red on an emergency-vehicle preemption. It sits above the per-head light drivers and is the only block that decides which approach owns the intersection.

## Interface
- `GREEN_TIME`, 8: green dwell in clock cycles, 1..2^TIMER_W
- `YELLOW_TIME`, 3: yellow dwell in cycles, 1..2^TIMER_W
- `ALL_RED_TIME`, 2: all-red clearance dwell in cycles, 1..2^TIMER_W
- `WALK_TIME`, 5: pedestrian walk dwell in cycles, 1..2^TIMER_W
- `TIMER_W`, 8: phase timer width
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- `ped_req`  in  1  pedestrian button, sampled each cycle, any width pulse
- `emergency`  in  1  preemption level, sampled each cycle
- `ns_lights`  out  3  {red,yellow,green}: 100 red, 010 yellow, 001 green
- `ew_lights`  out  3  same encoding
- `walk`  out  1  pedestrian walk indication
- `ped_pending`  out  1  latched, unserviced pedestrian request

## Operation
- States: ALL_RED, NS_GREEN, NS_YELLOW, EW_GREEN, EW_YELLOW, WALK. Outputs are a pure decode of the state register (Moore).
- ALL_RED, WALK: both heads 100. NS_*: EW is 100. EW_*: NS is 100. `walk`=1 only in WALK.
- ALL_RED has a registered 2-bit target ∈ {NS, EW, WALK} that selects its exit state.
- Normal sequence:
  - NS_GREEN → NS_YELLOW → ALL_RED(target EW) → EW_GREEN → EW_YELLOW.
  - EW_YELLOW → ALL_RED with target WALK if `ped_pending`, else NS.
  - WALK → ALL_RED(target NS) → NS_GREEN.
- Pedestrian latch:
  - `ped_pending` is set by `ped_req`=1.
  - It is cleared on the cycle WALK is entered.
  - Set wins over a simultaneous clear.
  - Repeated requests before service produce one walk.
- Emergency (`emergency`=1):
  - NS_GREEN or EW_GREEN: next state is the matching yellow, with the green time abandoned.
  - Yellow: completes its full YELLOW_TIME, then enters ALL_RED(target NS).
  - WALK: aborts to ALL_RED(target NS) next cycle. `ped_pending` is not re-set by the abort; the aborted walk is lost unless a new request arrives.
  - ALL_RED: timer held at reload, state held. On the first cycle `emergency`=0, a full ALL_RED_TIME clearance runs, then the exit is taken per target (NS).
- Reset:
  - State ALL_RED, target NS, `ped_pending`=0, timer loaded with ALL_RED_TIME−1.
  - Therefore `ns_lights`=`ew_lights`=100 and `walk`=0 during and immediately after reset.
  - Reset mid-operation aborts any phase with no yellow.

## Timing
- Phase timer loads duration−1 on state entry and decrements each cycle. The state exits on the edge where the timer is 0, so each state dwells exactly its parameter in cycles.
- Outputs change on the clock edge after the transition decision; there are no combinational input-to-output paths.
- `ped_req` is visible on `ped_pending` one cycle after sampling.
- `emergency` in green: the yellow appears on the next edge.
- Normal cycle length with no walk: 2·GREEN + 2·YELLOW + 2·ALL_RED cycles. A walk adds WALK + ALL_RED.
- Emergency and reset have priority over timer expiry in the same cycle. Reset has priority over everything.

## Structure
- Shared package `traffic_pkg`:
  - light encodings `LIGHT_RED`=100, `LIGHT_YELLOW`=010, `LIGHT_GREEN`=001
  - state enum
  - all-red target enum
- Sub-module `phase_timer`: TIMER_W down-counter with `load`, `load_val`, `hold` inputs and an `expired` output (count==0).
- The FSM, pedestrian latch and output decode live in the top module.

## Test plan
All scenarios use the default parameters.
1. Reset 2 cycles, release.
   - Both 100 for 2 cycles, then NS 001 for 8, NS 010 for 3, all-red 2, EW 001 8, EW 010 3, all-red 2, NS 001.
   - Full period is 26 cycles.
2. One-cycle `ped_req` during NS_GREEN.
   - `ped_pending`=1 next cycle.
   - After EW_YELLOW + 2 all-red: `walk`=1 with both 100 for 5 cycles, `ped_pending` cleared on WALK entry.
   - Then 2 all-red, then NS 001.
3. `emergency` raised on cycle 3 of EW_GREEN, held 10 cycles.
   - EW 010 next cycle for 3 cycles, then both 100 until release.
   - Then 2 more all-red cycles, then NS 001.
4. `emergency` raised on cycle 2 of WALK.
   - `walk`=0 next cycle, both 100 held.
   - On release: 2 all-red, then NS 001 with `ped_pending`=0.
5. Three `ped_req` pulses in one cycle period → exactly one WALK phase.
   - A pulse coincident with WALK entry leaves `ped_pending`=1 and yields a second WALK in the next period.
6. `reset` asserted on cycle 2 of NS_YELLOW.
   - Next edge: both 100, `ped_pending`=0.
   - After release: 2 all-red, then NS 001.
